if_fetch_unit: RTL and testbench

Instruction-fetch stage of the 5-stage RV32 pipeline. Holds the fetch PC, drives the instruction-memory request/acknowledge handshake, and presents the fetched instruction with its PC to the IF/ID pipeline register. It absorbs downstream stalls with a one-entry hold buffer and applies branch/jump redirects from EX, including redirects that arrive while a memory request is still outstanding.

---
 rtl/fetch_pkg.sv | 20 ++
 rtl/if_next_pc.sv | 50 +++++
 rtl/if_fetch_unit.sv | 123 ++++++++++++
 tb/tb_if_fetch_unit.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the RV32 instruction-fetch stage.
// Optional feature macro used by this slice: FETCH_MISALIGN_TRAP_EN.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2,
    KILL = 2'd3
  } fetch_state_e;

  localparam logic [31:0] PC_STEP      = 32'd4;
  localparam logic [31:0] INSTR_BUBBLE = 32'h0000_0000;
  localparam logic [31:0] ALIGN_MASK   = 32'hFFFF_FFFC;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & ALIGN_MASK;
  endfunction

endpackage

// File: rtl/if_next_pc.sv
// Combinational next-PC selection for the fetch stage: hold, +4, redirect or pending target.
// With FETCH_MISALIGN_TRAP_EN defined it also flags accepted redirects with nonzero low bits.
module if_next_pc
  import fetch_pkg::*;
(
  input  fetch_state_e state_i,
  input  logic [31:0]  pc_i,
  input  logic [31:0]  pend_pc_i,
  input  logic         stall_i,
  input  logic         redirect_i,
  input  logic [31:0]  redirect_pc_i,
  input  logic         imem_ack_i,
  output logic [31:0]  pc_d_o,
  output logic [31:0]  target_o
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic         misalign_o
`endif
);

  logic [31:0] pc_inc;

  assign target_o = align_word(redirect_pc_i);
  assign pc_inc   = pc_i + PC_STEP;

`ifdef FETCH_MISALIGN_TRAP_EN
  // IDLE lasts one cycle after reset and does not accept redirects.
  assign misalign_o = redirect_i && (state_i != IDLE) && (redirect_pc_i[1:0] != 2'b00);
`endif

  always_comb begin
    pc_d_o = pc_i;
    case (state_i)
      REQ: begin
        // A redirect without ack keeps the old address until the request completes.
        if (redirect_i && imem_ack_i)       pc_d_o = target_o;
        else if (imem_ack_i && !stall_i)    pc_d_o = pc_inc;
      end
      HOLD: begin
        if (redirect_i)                     pc_d_o = target_o;
        else if (!stall_i)                  pc_d_o = pc_inc;
      end
      KILL: begin
        if (imem_ack_i)                     pc_d_o = redirect_i ? target_o : pend_pc_i;
      end
      default: pc_d_o = pc_i;
    endcase
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC register, imem handshake, one-entry hold buffer, redirect handling.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN (adds misalign_o).
//
// state | meaning
// IDLE  | one cycle after reset, no request
// REQ   | request at pc outstanding; ack data is passed straight through
// HOLD  | downstream stalled, instruction replayed from the hold buffer
// KILL  | request outstanding whose data will be discarded, then go to pend_pc
module if_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] PCF,
  output logic [31:0] InstrF,
  output logic        ValidF
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic        misalign_o
`endif
);

  fetch_state_e state_q;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  pend_pc_q;
  logic [31:0]  buf_q;
  logic         req_q;
  logic [31:0]  target;

  if_next_pc u_next_pc (
    .state_i       (state_q),
    .pc_i          (pc_q),
    .pend_pc_i     (pend_pc_q),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_ack_i    (imem_ack_i),
    .pc_d_o        (pc_d),
    .target_o      (target)
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    .misalign_o    (misalign_o)
`endif
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      pend_pc_q <= '0;
      buf_q     <= INSTR_BUBBLE;
      req_q     <= 1'b0;
    end else begin
      pc_q <= pc_d;
      case (state_q)
        IDLE: begin
          state_q <= REQ;
          req_q   <= 1'b1;
        end
        REQ: begin
          if (redirect_i && !imem_ack_i) begin
            state_q   <= KILL;
            pend_pc_q <= target;
          end else if (imem_ack_i && stall_i && !redirect_i) begin
            buf_q   <= imem_rdata_i;
            state_q <= HOLD;
            req_q   <= 1'b0;
          end
        end
        HOLD: begin
          if (redirect_i || !stall_i) begin
            state_q <= REQ;
            req_q   <= 1'b1;
          end
        end
        KILL: begin
          if (imem_ack_i)      state_q   <= REQ;
          else if (redirect_i) pend_pc_q <= target;
        end
        default: begin
          state_q <= IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  // Ack data bypasses the buffer so a zero-wait memory sustains one instruction per cycle.
  always_comb begin
    ValidF = 1'b0;
    InstrF = INSTR_BUBBLE;
    case (state_q)
      REQ: begin
        if (imem_ack_i) begin
          InstrF = imem_rdata_i;
          ValidF = !redirect_i;
        end
      end
      HOLD: begin
        InstrF = buf_q;
        ValidF = !redirect_i;
      end
      default: begin
        ValidF = 1'b0;
        InstrF = INSTR_BUBBLE;
      end
    endcase
  end

  assign imem_req_o  = req_q;
  assign imem_addr_o = pc_q;
  assign PCF         = pc_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Scoreboard bench for if_fetch_unit: expected request addresses and delivered PCs are
// queued as stimulus is driven and compared when the DUT requests or presents an instruction.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        stall_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i = 1'b0;
  logic [31:0] imem_rdata_i = '0;
  logic [31:0] PCF;
  logic [31:0] InstrF;
  logic        ValidF;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        misalign_o;
`endif

  if_fetch_unit #(.RESET_PC(32'h0000_0100)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_ack_i    (imem_ack_i),
    .imem_rdata_i  (imem_rdata_i),
    .PCF           (PCF),
    .InstrF        (InstrF),
    .ValidF        (ValidF)
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    .misalign_o    (misalign_o)
`endif
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;
  int wait_n  = 0;
  int wcnt    = 0;

  logic [31:0] exp_req[$];
  logic [31:0] exp_fetch[$];

  logic        req_last, valid_last, mis_last;
  logic [31:0] pcf_last, instr_last;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs and memory response, observe at negedge, advance.
  task automatic tick(input logic st, input logic rd, input logic [31:0] rp);
    logic        req_s, ack_s;
    logic [31:0] e;
    stall_i       = st;
    redirect_i    = rd;
    redirect_pc_i = rp;
    imem_ack_i    = imem_req_o && (wcnt >= wait_n);
    imem_rdata_i  = imem_ack_i ? mem_fn(imem_addr_o) : 32'hDEAD_BEEF;
    @(negedge clk);
    req_s      = imem_req_o;
    ack_s      = imem_ack_i;
    req_last   = imem_req_o;
    valid_last = ValidF;
    pcf_last   = PCF;
    instr_last = InstrF;
`ifdef FETCH_MISALIGN_TRAP_EN
    mis_last   = misalign_o;
`else
    mis_last   = 1'b0;
`endif
    if (imem_req_o) begin
      if (exp_req.size() == 0) check_val("req_extra", 32'(imem_req_o), 32'h0);
      else begin
        check_val("req_addr", imem_addr_o, exp_req[0]);
        if (imem_ack_i) void'(exp_req.pop_front());
      end
    end
    if (ValidF && !st) begin
      if (exp_fetch.size() == 0) check_val("fetch_extra", 32'(ValidF), 32'h0);
      else begin
        e = exp_fetch.pop_front();
        check_val("pcf", PCF, e);
        check_val("instr", InstrF, mem_fn(e));
      end
    end
    @(posedge clk);
    #1;
    if (req_s && ack_s) wcnt = 0;
    else if (req_s)     wcnt = wcnt + 1;
    else                wcnt = 0;
  endtask

  task automatic do_reset();
    stall_i    = 1'b0;
    redirect_i = 1'b0;
    imem_ack_i = 1'b0;
    rst_n      = 1'b0;
    #1;
    check_val("async_req_drop", 32'(imem_req_o), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_req", 32'(imem_req_o), 32'h0);
    check_val("rst_addr", imem_addr_o, 32'h100);
    check_val("rst_pcf", PCF, 32'h100);
    check_val("rst_instr", InstrF, 32'h0);
    check_val("rst_valid", 32'(ValidF), 32'h0);
`ifdef FETCH_MISALIGN_TRAP_EN
    check_val("rst_misalign", 32'(misalign_o), 32'h0);
`endif
    exp_req.delete();
    exp_fetch.delete();
    wcnt  = 0;
    rst_n = 1'b1;
  endtask

  task automatic check_drained();
    check_val("req_left", 32'(exp_req.size()), 32'h0);
    check_val("fetch_left", 32'(exp_fetch.size()), 32'h0);
  endtask

  initial begin
    @(posedge clk);
    #1;

    // Zero-wait streaming from RESET_PC.
    do_reset();
    wait_n = 0;
    foreach (exp_req[i]) ;
    for (int i = 0; i < 4; i++) begin
      exp_req.push_back(32'h100 + 32'(4 * i));
      exp_fetch.push_back(32'h100 + 32'(4 * i));
    end
    tick(1'b0, 1'b0, 32'h0);
    check_val("idle_valid", 32'(valid_last), 32'h0);
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 1'b0, 32'h0);
      check_val("stream_valid", 32'(valid_last), 32'h1);
    end
    check_drained();

    // 2-wait memory continuing from 0x110, no reset in between.
    wait_n = 2;
    exp_req.push_back(32'h110);  exp_fetch.push_back(32'h110);
    exp_req.push_back(32'h114);  exp_fetch.push_back(32'h114);
    for (int i = 0; i < 6; i++) begin
      tick(1'b0, 1'b0, 32'h0);
      check_val("wait2_valid", 32'(valid_last), 32'((i % 3) == 2));
    end
    check_drained();

    // Stall on the acked 0x104 fetch, then release.
    do_reset();
    wait_n = 0;
    exp_req.push_back(32'h100);  exp_fetch.push_back(32'h100);
    exp_req.push_back(32'h104);  exp_fetch.push_back(32'h104);
    tick(1'b0, 1'b0, 32'h0);
    tick(1'b0, 1'b0, 32'h0);
    tick(1'b1, 1'b0, 32'h0);
    check_val("stall_ack_valid", 32'(valid_last), 32'h1);
    for (int i = 0; i < 2; i++) begin
      tick(1'b1, 1'b0, 32'h0);
      check_val("hold_req", 32'(req_last), 32'h0);
      check_val("hold_valid", 32'(valid_last), 32'h1);
      check_val("hold_pcf", pcf_last, 32'h104);
      check_val("hold_instr", instr_last, mem_fn(32'h104));
    end
    tick(1'b0, 1'b0, 32'h0);
    exp_req.push_back(32'h108);  exp_fetch.push_back(32'h108);
    tick(1'b0, 1'b0, 32'h0);
    check_drained();

    // Redirect during a wait cycle, then two redirects while killing.
    do_reset();
    wait_n = 2;
    exp_req.push_back(32'h100);  exp_fetch.push_back(32'h100);
    exp_req.push_back(32'h104);  exp_fetch.push_back(32'h104);
    exp_req.push_back(32'h108);
    exp_req.push_back(32'h200);  exp_fetch.push_back(32'h200);
    tick(1'b0, 1'b0, 32'h0);
    repeat (6) tick(1'b0, 1'b0, 32'h0);
    tick(1'b0, 1'b1, 32'h200);
    check_val("redir_wait_valid", 32'(valid_last), 32'h0);
    tick(1'b0, 1'b0, 32'h0);
    check_val("kill_wait_valid", 32'(valid_last), 32'h0);
    tick(1'b0, 1'b0, 32'h0);
    check_val("kill_ack_valid", 32'(valid_last), 32'h0);
    repeat (3) tick(1'b0, 1'b0, 32'h0);
    exp_req.push_back(32'h204);
    exp_req.push_back(32'h400);  exp_fetch.push_back(32'h400);
    tick(1'b0, 1'b1, 32'h300);
    tick(1'b0, 1'b1, 32'h400);
    tick(1'b0, 1'b0, 32'h0);
    check_val("kill2_ack_valid", 32'(valid_last), 32'h0);
    repeat (3) tick(1'b0, 1'b0, 32'h0);
    check_drained();

    // Redirect beats stall in REQ and HOLD; pc wrap at the top of memory.
    do_reset();
    wait_n = 0;
    exp_req.push_back(32'h100);  exp_fetch.push_back(32'h100);
    exp_req.push_back(32'h104);
    exp_req.push_back(32'h500);  exp_fetch.push_back(32'h500);
    exp_req.push_back(32'h504);
    exp_req.push_back(32'hFFFF_FFFC); exp_fetch.push_back(32'hFFFF_FFFC);
    exp_req.push_back(32'h0);    exp_fetch.push_back(32'h0);
    exp_req.push_back(32'h4);    exp_fetch.push_back(32'h4);
    exp_req.push_back(32'h8);
    exp_req.push_back(32'h20);   exp_fetch.push_back(32'h20);
    tick(1'b0, 1'b0, 32'h0);
    tick(1'b0, 1'b0, 32'h0);
    tick(1'b1, 1'b1, 32'h500);
    check_val("redir_stall_valid", 32'(valid_last), 32'h0);
    tick(1'b0, 1'b0, 32'h0);
    tick(1'b0, 1'b1, 32'hFFFF_FFFC);
    repeat (3) tick(1'b0, 1'b0, 32'h0);
    tick(1'b1, 1'b0, 32'h0);
    tick(1'b1, 1'b1, 32'h20);
    check_val("hold_redir_valid", 32'(valid_last), 32'h0);
    check_val("hold_redir_req", 32'(req_last), 32'h0);
    tick(1'b0, 1'b0, 32'h0);
    check_drained();

    // Misaligned redirect target is aligned (and flagged when the trap is built in).
    do_reset();
    wait_n = 0;
    exp_req.push_back(32'h100);
    exp_req.push_back(32'h200);  exp_fetch.push_back(32'h200);
    tick(1'b0, 1'b0, 32'h0);
    tick(1'b0, 1'b1, 32'h202);
`ifdef FETCH_MISALIGN_TRAP_EN
    check_val("misalign_pulse", 32'(mis_last), 32'h1);
`endif
    tick(1'b0, 1'b0, 32'h0);
`ifdef FETCH_MISALIGN_TRAP_EN
    check_val("misalign_clear", 32'(mis_last), 32'h0);
`endif
    check_drained();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
